// File: rtl/uart_msg_link.sv
// UART transceiver with RX FIFO and a byte sequencer that either sends a fixed
// message on a trigger edge or echoes received bytes back out on txd.
module uart_msg_link #(
   parameter int unsigned         CLK_HZ     = 100_000_000,
   parameter int unsigned         BAUD       = 115200,
   parameter int unsigned         PARITY     = 0,
   parameter int unsigned         STOP_BITS  = 1,
   parameter int unsigned         FIFO_DEPTH = 8,
   parameter int unsigned         MSG_LEN    = 8,
   parameter logic [8*MSG_LEN-1:0] MSG       = "23001234"
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rxd,
   output logic                            txd,
   input  logic                            send_trig,
   input  logic                            echo_en,
   input  logic                            rx_pop,
   output logic [7:0]                      rx_data,
   output logic                            rx_empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
   output logic                            rx_frame_err,
   output logic                            rx_par_err,
   output logic                            rx_overrun,
   output logic                            tx_busy
);

   localparam int unsigned DIV = CLK_HZ / BAUD;
   localparam int unsigned CW  = $clog2(DIV);
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned NW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned IW  = $clog2(MSG_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxPar, RxStop} rx_state_e;
   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxPar, TxStop} tx_state_e;
   typedef enum logic [1:0] {SqIdle, SqMsg, SqEcho} sq_state_e;

   // Parity bit that accompanies a byte: odd or even depending on PARITY.
   function automatic logic par_of(input logic [7:0] b);
      return (PARITY == 1) ? ~^b : ^b;
   endfunction

   // ---------------- RX ----------------
   logic            rx_s1_q, rx_s2_q, rx_s3_q;
   rx_state_e       rx_state_q, rx_state_d;
   logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_sh_q, rx_sh_d;
   logic            rx_pbit_q, rx_pbit_d;
   logic            rx_good, ferr_d, perr_d, ovr_d;
   logic            rx_fall;

   assign rx_fall = rx_s3_q & ~rx_s2_q;

   // Synchroniser, RX state and error pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_s3_q      <= 1'b1;
         rx_state_q   <= RxIdle;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_sh_q      <= '0;
         rx_pbit_q    <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_par_err   <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         rx_s1_q      <= rxd;
         rx_s2_q      <= rx_s1_q;
         rx_s3_q      <= rx_s2_q;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_sh_q      <= rx_sh_d;
         rx_pbit_q    <= rx_pbit_d;
         rx_frame_err <= ferr_d;
         rx_par_err   <= perr_d;
         rx_overrun   <= ovr_d;
      end
   end

   // RX next state: centre-sample each bit, judge the frame at the stop sample.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + CW'(1);
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_pbit_d  = rx_pbit_q;
      rx_good    = 1'b0;
      ferr_d     = 1'b0;
      perr_d     = 1'b0;
      case (rx_state_q)
         RxIdle: begin
            rx_cnt_d = '0;
            if (rx_fall) rx_state_d = RxStart;
         end
         RxStart: begin
            if (rx_cnt_q == HALF) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (rx_cnt_q == LAST) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = (PARITY != 0) ? RxPar : RxStop;
            end
         end
         RxPar: begin
            if (rx_cnt_q == LAST) begin
               rx_cnt_d   = '0;
               rx_pbit_d  = rx_s2_q;
               rx_state_d = RxStop;
            end
         end
         RxStop: begin
            if (rx_cnt_q == LAST) begin
               rx_state_d = RxIdle;
               if (!rx_s2_q) ferr_d = 1'b1;
               else if (PARITY != 0 && rx_pbit_q != par_of(rx_sh_q)) perr_d = 1'b1;
               else rx_good = 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   // ---------------- FIFO ----------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [NW-1:0] count_q;
   logic          full, seq_pop, pop_ok, push_ok;

   assign rx_empty = (count_q == '0);
   assign full     = (count_q == NW'(FIFO_DEPTH));
   assign rx_count = count_q;
   assign rx_data  = rx_empty ? 8'h00 : mem_q[rd_ptr_q];
   // Sequencer pops in echo mode; rx_pop only counts when echo is off.
   assign pop_ok   = (seq_pop | (~echo_en & rx_pop)) & ~rx_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok  = rx_good & (~full | pop_ok);
   assign ovr_d    = rx_good & full & ~pop_ok;

   // FIFO storage, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= rx_sh_q;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push_ok && !pop_ok)      count_q <= count_q + NW'(1);
         else if (pop_ok && !push_ok) count_q <= count_q - NW'(1);
      end
   end

   // ---------------- TX ----------------
   tx_state_e     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_sh_q, tx_sh_d;
   logic          tx_par_q, tx_par_d;
   logic          txd_d;
   logic          tx_ready, tx_load;
   logic [7:0]    tx_byte;

   // Ready also in the final stop cycle so message bytes go out back-to-back.
   assign tx_ready = (tx_state_q == TxIdle) ||
                     (tx_state_q == TxStop && tx_cnt_q == LAST &&
                      tx_bit_q == 3'(STOP_BITS - 1));
   assign tx_busy  = (tx_state_q != TxIdle);

   // TX state and registered line output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         txd        <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         txd        <= txd_d;
      end
   end

   // TX next state: each bit held for DIV clocks; a load restarts at the start bit.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + CW'(1);
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      case (tx_state_q)
         TxIdle: tx_cnt_d = '0;
         TxStart: begin
            if (tx_cnt_q == LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TxData;
            end
         end
         TxData: begin
            if (tx_cnt_q == LAST) begin
               tx_cnt_d = '0;
               tx_sh_d  = {1'b0, tx_sh_q[7:1]};
               tx_bit_d = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) begin
                  tx_bit_d   = '0;
                  tx_state_d = (PARITY != 0) ? TxPar : TxStop;
               end
            end
         end
         TxPar: begin
            if (tx_cnt_q == LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TxStop;
            end
         end
         TxStop: begin
            if (tx_cnt_q == LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'(STOP_BITS - 1)) tx_state_d = TxIdle;
               else tx_bit_d = tx_bit_q + 3'd1;
            end
         end
         default: tx_state_d = TxIdle;
      endcase
      if (tx_load) begin
         tx_state_d = TxStart;
         tx_cnt_d   = '0;
         tx_bit_d   = '0;
         tx_sh_d    = tx_byte;
         tx_par_d   = par_of(tx_byte);
      end
      case (tx_state_d)
         TxStart: txd_d = 1'b0;
         TxData:  txd_d = tx_sh_d[0];
         TxPar:   txd_d = tx_par_d;
         default: txd_d = 1'b1;
      endcase
   end

   // ---------------- Sequencer ----------------
   sq_state_e          sq_q, sq_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic               loaded_q, loaded_d;
   logic               trig_q;
   logic [8*MSG_LEN-1:0] msg_sh;

   assign msg_sh = MSG << {idx_q, 3'b000};

   // Sequencer state and trigger edge history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sq_q     <= SqIdle;
         idx_q    <= '0;
         loaded_q <= 1'b0;
         trig_q   <= 1'b0;
      end else begin
         sq_q     <= sq_d;
         idx_q    <= idx_d;
         loaded_q <= loaded_d;
         trig_q   <= send_trig;
      end
   end

   // Sequencer next state and TX byte offer.
   always_comb begin
      sq_d     = sq_q;
      idx_d    = idx_q;
      loaded_d = loaded_q;
      tx_load  = 1'b0;
      tx_byte  = 8'h00;
      seq_pop  = 1'b0;
      case (sq_q)
         SqIdle: begin
            loaded_d = 1'b0;
            if (send_trig && !trig_q) begin
               sq_d  = SqMsg;
               idx_d = '0;
            end else if (echo_en && !rx_empty) begin
               sq_d = SqEcho;
            end
         end
         SqMsg: begin
            if (tx_ready) begin
               if (idx_q == IW'(MSG_LEN)) begin
                  sq_d = SqIdle;
               end else begin
                  tx_load = 1'b1;
                  tx_byte = msg_sh[8*MSG_LEN-1 -: 8];
                  idx_d   = idx_q + IW'(1);
               end
            end
         end
         SqEcho: begin
            if (tx_ready) begin
               if (loaded_q || rx_empty) begin
                  sq_d = SqIdle;
               end else begin
                  tx_load  = 1'b1;
                  tx_byte  = rx_data;
                  seq_pop  = 1'b1;
                  loaded_d = 1'b1;
               end
            end
         end
         default: sq_d = SqIdle;
      endcase
   end

endmodule

// File: tb/tb_uart_msg_link.sv
// Directed bench for uart_msg_link: DIV=10, even parity, 1 stop, 8-deep FIFO, "ABC".
module tb_uart_msg_link;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic       txd;
   logic       send_trig = 1'b0;
   logic       echo_en = 1'b0;
   logic       rx_pop = 1'b0;
   logic [7:0] rx_data;
   logic       rx_empty;
   logic [3:0] rx_count;
   logic       rx_frame_err, rx_par_err, rx_overrun, tx_busy;

   int n_checks = 0;
   int n_err    = 0;
   int par_cnt  = 0;
   int frm_cnt  = 0;
   int ovr_cnt  = 0;

   uart_msg_link #(
      .CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(1),
      .FIFO_DEPTH(8), .MSG_LEN(3), .MSG(24'h414243)
   ) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .send_trig(send_trig),
      .echo_en(echo_en), .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty),
      .rx_count(rx_count), .rx_frame_err(rx_frame_err), .rx_par_err(rx_par_err),
      .rx_overrun(rx_overrun), .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;

   // Count one-cycle error pulses.
   always @(negedge clk) begin
      if (rx_par_err)   par_cnt++;
      if (rx_frame_err) frm_cnt++;
      if (rx_overrun)   ovr_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one 11-bit frame on rxd (start, 8 data LSB first, even parity, stop).
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      logic [10:0] bits;
      bits = {~bad_stop, (^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rxd = bits[i];
         repeat (10) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Wait (bounded) for a start bit on txd and sample the frame mid-bit.
   task automatic tx_capture(input string tag, output logic [7:0] data, output logic par);
      int waited;
      waited = 0;
      data = 8'h00;
      par = 1'b0;
      while (txd !== 1'b0 && waited < 600) begin
         @(negedge clk);
         waited++;
      end
      if (txd !== 1'b0) begin
         chk({tag, " start timeout"}, 32'(txd), 32'd0);
         return;
      end
      repeat (4) @(negedge clk);
      chk({tag, " start bit"}, 32'(txd), 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (10) @(negedge clk);
         data[i] = txd;
      end
      repeat (10) @(negedge clk);
      par = txd;
      chk({tag, " parity"}, 32'(par), 32'(^data));
      repeat (10) @(negedge clk);
      chk({tag, " stop bit"}, 32'(txd), 32'd1);
   endtask

   logic [7:0] got;
   logic       gpar;
   int         p0, f0, lows;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst txd", 32'(txd), 32'd1);
      chk("rst tx_busy", 32'(tx_busy), 32'd0);
      chk("rst rx_empty", 32'(rx_empty), 32'd1);
      chk("rst rx_count", 32'(rx_count), 32'd0);
      chk("rst rx_data", 32'(rx_data), 32'h00);
      chk("rst err pulses", 32'({rx_frame_err, rx_par_err, rx_overrun}), 32'd0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // Good frame 0x55
      send_frame(8'h55, 1'b0, 1'b0);
      chk("rx 55 empty", 32'(rx_empty), 32'd0);
      chk("rx 55 data", 32'(rx_data), 32'h55);
      chk("rx 55 count", 32'(rx_count), 32'd1);
      rx_pop = 1'b1;
      @(negedge clk);
      rx_pop = 1'b0;
      chk("pop count", 32'(rx_count), 32'd0);

      // Parity error, then framing error
      p0 = par_cnt;
      f0 = frm_cnt;
      send_frame(8'h31, 1'b1, 1'b0);
      chk("par_err pulse", 32'(par_cnt - p0), 32'd1);
      chk("par_err count", 32'(rx_count), 32'd0);
      send_frame(8'h31, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      chk("frame_err pulse", 32'(frm_cnt - f0), 32'd1);
      chk("frame_err count", 32'(rx_count), 32'd0);

      // Nine frames into an 8-deep FIFO
      for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
      chk("full count", 32'(rx_count), 32'd8);
      chk("overrun pulse", 32'(ovr_cnt), 32'd1);
      for (int i = 0; i < 8; i++) begin
         chk("fifo order", 32'(rx_data), 32'(8'h10 + 8'(i)));
         rx_pop = 1'b1;
         @(negedge clk);
         rx_pop = 1'b0;
      end
      chk("drained empty", 32'(rx_empty), 32'd1);
      rx_pop = 1'b1;
      @(negedge clk);
      rx_pop = 1'b0;
      chk("pop on empty", 32'(rx_count), 32'd0);

      // Message on trigger, with a retrigger mid-message
      send_trig = 1'b1;
      fork
         begin
            tx_capture("msg0", got, gpar);
            chk("msg byte0", 32'(got), 32'h41);
            tx_capture("msg1", got, gpar);
            chk("msg byte1", 32'(got), 32'h42);
            tx_capture("msg2", got, gpar);
            chk("msg byte2", 32'(got), 32'h43);
         end
         begin
            repeat (331) @(negedge clk);
            chk("busy end-1", 32'(tx_busy), 32'd1);
            @(negedge clk);
            chk("busy end", 32'(tx_busy), 32'd0);
         end
         begin
            repeat (150) @(negedge clk);
            send_trig = 1'b0;
            repeat (10) @(negedge clk);
            send_trig = 1'b1;
            repeat (10) @(negedge clk);
            send_trig = 1'b0;
         end
      join
      lows = 0;
      repeat (150) begin
         @(negedge clk);
         if (txd === 1'b0) lows++;
      end
      chk("retrigger ignored", 32'(lows), 32'd0);

      // Echo mode; rx_pop toggling must not steal the byte
      echo_en = 1'b1;
      fork
         send_frame(8'h5A, 1'b0, 1'b0);
         begin
            tx_capture("echo", got, gpar);
            chk("echo byte", 32'(got), 32'h5A);
            chk("echo parity bit", 32'(gpar), 32'd0);
         end
         repeat (300) begin
            @(negedge clk);
            rx_pop = ~rx_pop;
         end
      join
      rx_pop = 1'b0;
      chk("echo popped", 32'(rx_count), 32'd0);
      echo_en = 1'b0;
      repeat (20) @(negedge clk);

      // Reset in the middle of a TX data bit
      send_frame(8'h77, 1'b0, 1'b0);
      chk("pre-reset count", 32'(rx_count), 32'd1);
      send_trig = 1'b1;
      repeat (25) @(negedge clk);
      chk("txd data bit1 low", 32'(txd), 32'd0);
      rst = 1'b0;
      send_trig = 1'b0;
      #1;
      chk("async rst txd", 32'(txd), 32'd1);
      chk("async rst busy", 32'(tx_busy), 32'd0);
      chk("async rst empty", 32'(rx_empty), 32'd1);
      chk("async rst count", 32'(rx_count), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      send_trig = 1'b1;
      tx_capture("re0", got, gpar);
      chk("re byte0", 32'(got), 32'h41);
      tx_capture("re1", got, gpar);
      chk("re byte1", 32'(got), 32'h42);
      tx_capture("re2", got, gpar);
      chk("re byte2", 32'(got), 32'h43);
      send_trig = 1'b0;
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
